// File: rtl/mure_retire_sequencer.sv
// Retire sequencer: serialises CVA6 multi-retirement bundles into single trace records.
// Optional statistics counters are built when MURE_SEQ_STATS_EN is defined.
package mure_pkg;
    localparam int unsigned XLEN      = 64;
    localparam int unsigned INST_LEN  = 32;
    localparam int unsigned CAUSE_LEN = 6;
endpackage

// Purpose: buffer commit bundles, emit retired slots in order then the bundle trap.
// Latency: a bundle accepted in cycle N is presented from cycle N+1.
// Backpressure: out_ready_i low holds the record; bundle_ready_o drops while the FIFO is full.
module mure_retire_sequencer
    import mure_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     bundle_valid_i,
    output logic                     bundle_ready_o,
    input  logic [NRET-1:0]          valids_i,
    input  logic [NRET*XLEN-1:0]     pc_i,
    input  logic [NRET*INST_LEN-1:0] inst_i,
    input  logic [NRET-1:0]          compressed_i,
    input  logic                     exception_i,
    input  logic                     interrupt_i,
    input  logic [CAUSE_LEN-1:0]     cause_i,
    input  logic [XLEN-1:0]          tval_i,
    input  logic [XLEN-1:0]          epc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_iretired_o,
    output logic                     out_exception_o,
    output logic                     out_interrupt_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [INST_LEN-1:0]      out_inst_o,
    output logic                     out_compressed_o,
    output logic [CAUSE_LEN-1:0]     out_cause_o,
    output logic [XLEN-1:0]          out_tval_o,
    output logic                     out_last_o
`ifdef MURE_SEQ_STATS_EN
    ,
    output logic [31:0]              stat_bundles_o,
    output logic [31:0]              stat_retired_o,
    output logic [31:0]              stat_stall_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned KW = (NRET > 1) ? $clog2(NRET) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [NRET-1:0]          valids;
        logic [NRET*XLEN-1:0]     pc;
        logic [NRET*INST_LEN-1:0] inst;
        logic [NRET-1:0]          compressed;
        logic                     exc;
        logic                     irq;
        logic [CAUSE_LEN-1:0]     cause;
        logic [XLEN-1:0]          tval;
        logic [XLEN-1:0]          epc;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TRAP} state_e;

    state_e         state_q, state_d;
    entry_t         mem_q [DEPTH];
    entry_t         in_ent, head;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d, cnt_left;
    logic [NRET-1:0] done_q, done_d, rem, rem_after, kbit, nxt_valids;
    logic [KW-1:0]  kidx;
    int unsigned    ksel;
    logic           push, pop, hs, has_trap;
    state_e         after_pop_state;

    // Interrupt has priority when both trap kinds arrive in one bundle.
    always_comb begin
        in_ent            = '0;
        in_ent.valids     = valids_i;
        in_ent.pc         = pc_i;
        in_ent.inst       = inst_i;
        in_ent.compressed = compressed_i;
        in_ent.exc        = exception_i & ~interrupt_i;
        in_ent.irq        = interrupt_i;
        in_ent.cause      = cause_i;
        in_ent.tval       = tval_i;
        in_ent.epc        = epc_i;
    end

    assign bundle_ready_o = (count_q != FULL_CNT);
    assign push     = bundle_valid_i & bundle_ready_o & ((|valids_i) | exception_i | interrupt_i);
    assign head     = mem_q[rd_ptr_q];
    assign has_trap = head.exc | head.irq;
    assign rem      = head.valids & ~done_q;
    assign hs       = out_valid_o & out_ready_i;

    always_comb begin
        kidx = '0;
        for (int i = int'(NRET) - 1; i >= 0; i--) begin
            if (rem[i]) kidx = KW'(i);
        end
    end

    assign ksel      = 32'(kidx);
    assign kbit      = NRET'(1) << kidx;
    assign rem_after = rem & ~kbit;

    // Where the FSM lands after a pop depends on the entry that becomes head.
    assign cnt_left   = count_q - (AW+1)'(1);
    assign nxt_valids = (cnt_left != '0) ? mem_q[rd_ptr_q + AW'(1)].valids : valids_i;

    always_comb begin
        if ((cnt_left == '0) && !push) after_pop_state = S_IDLE;
        else if (|nxt_valids)          after_pop_state = S_DRAIN;
        else                           after_pop_state = S_TRAP;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (push) state_d = (|valids_i) ? S_DRAIN : S_TRAP;
            end
            S_DRAIN: begin
                if (hs && (rem_after == '0)) begin
                    if (has_trap) begin
                        state_d = S_TRAP;
                    end else begin
                        pop     = 1'b1;
                        state_d = after_pop_state;
                    end
                end
            end
            S_TRAP: begin
                if (hs) begin
                    pop     = 1'b1;
                    state_d = after_pop_state;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_o      = 1'b0;
        out_iretired_o   = 1'b0;
        out_exception_o  = 1'b0;
        out_interrupt_o  = 1'b0;
        out_pc_o         = '0;
        out_inst_o       = '0;
        out_compressed_o = 1'b0;
        out_cause_o      = '0;
        out_tval_o       = '0;
        out_last_o       = 1'b0;
        case (state_q)
            S_DRAIN: begin
                out_valid_o      = 1'b1;
                out_iretired_o   = 1'b1;
                out_pc_o         = head.pc[ksel*XLEN +: XLEN];
                out_inst_o       = head.inst[ksel*INST_LEN +: INST_LEN];
                out_compressed_o = head.compressed[kidx];
                out_last_o       = (rem_after == '0) && !has_trap;
            end
            S_TRAP: begin
                out_valid_o     = 1'b1;
                out_exception_o = head.exc;
                out_interrupt_o = head.irq;
                out_pc_o        = head.epc;
                out_cause_o     = head.cause;
                out_tval_o      = head.tval;
                out_last_o      = 1'b1;
            end
            default: ;
        endcase
    end

    // Slots already handed over for the head entry; cleared whenever the head moves on.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        done_d   = done_q;
        if (pop)                              done_d = '0;
        else if (hs && (state_q == S_DRAIN))  done_d = done_q | kbit;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_ent;
    end

`ifdef MURE_SEQ_STATS_EN
    logic [31:0] stat_bundles_q, stat_retired_q, stat_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_bundles_q <= '0;
            stat_retired_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (push && (stat_bundles_q != '1))
                stat_bundles_q <= stat_bundles_q + 32'd1;
            if (hs && (state_q == S_DRAIN) && (stat_retired_q != '1))
                stat_retired_q <= stat_retired_q + 32'd1;
            if (bundle_valid_i && !bundle_ready_o && (stat_stall_q != '1))
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_bundles_o = stat_bundles_q;
    assign stat_retired_o = stat_retired_q;
    assign stat_stall_o   = stat_stall_q;
`endif

endmodule

// File: tb/tb_mure_retire_sequencer.sv
// Bench for mure_retire_sequencer: directed vector table, corner sequences, random run against a queue model.
module tb_mure_retire_sequencer;
    import mure_pkg::*;

    localparam int unsigned NRET  = 2;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic                 iret;
        logic                 exc;
        logic                 irq;
        logic [XLEN-1:0]      pc;
        logic [INST_LEN-1:0]  inst;
        logic                 comp;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic                 last;
    } rec_t;

    typedef struct packed {
        logic [NRET-1:0]          valids;
        logic [NRET*XLEN-1:0]     pc;
        logic [NRET*INST_LEN-1:0] inst;
        logic [NRET-1:0]          comp;
        logic                     exc;
        logic                     irq;
        logic [CAUSE_LEN-1:0]     cause;
        logic [XLEN-1:0]          tval;
        logic [XLEN-1:0]          epc;
    } bun_t;

    typedef struct {
        bun_t b;
        int   n;
        rec_t exp [3];
    } vec_t;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     bundle_valid_i;
    logic                     bundle_ready_o;
    logic [NRET-1:0]          valids_i;
    logic [NRET*XLEN-1:0]     pc_i;
    logic [NRET*INST_LEN-1:0] inst_i;
    logic [NRET-1:0]          compressed_i;
    logic                     exception_i;
    logic                     interrupt_i;
    logic [CAUSE_LEN-1:0]     cause_i;
    logic [XLEN-1:0]          tval_i;
    logic [XLEN-1:0]          epc_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic                     out_iretired_o;
    logic                     out_exception_o;
    logic                     out_interrupt_o;
    logic [XLEN-1:0]          out_pc_o;
    logic [INST_LEN-1:0]      out_inst_o;
    logic                     out_compressed_o;
    logic [CAUSE_LEN-1:0]     out_cause_o;
    logic [XLEN-1:0]          out_tval_o;
    logic                     out_last_o;
`ifdef MURE_SEQ_STATS_EN
    logic [31:0]              stat_bundles_o, stat_retired_o, stat_stall_o;
`endif

    always #5 clk_i = ~clk_i;

    mure_retire_sequencer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bundle_valid_i(bundle_valid_i), .bundle_ready_o(bundle_ready_o),
        .valids_i(valids_i), .pc_i(pc_i), .inst_i(inst_i), .compressed_i(compressed_i),
        .exception_i(exception_i), .interrupt_i(interrupt_i), .cause_i(cause_i),
        .tval_i(tval_i), .epc_i(epc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_iretired_o(out_iretired_o), .out_exception_o(out_exception_o),
        .out_interrupt_o(out_interrupt_o), .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
        .out_compressed_o(out_compressed_o), .out_cause_o(out_cause_o),
        .out_tval_o(out_tval_o), .out_last_o(out_last_o)
`ifdef MURE_SEQ_STATS_EN
        , .stat_bundles_o(stat_bundles_o), .stat_retired_o(stat_retired_o), .stat_stall_o(stat_stall_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    rec_t exp_q [$];
    int   bcnt_q [$];
    vec_t vecs [6];
    bun_t rb;
    logic rbv, exp_rdy;
    rec_t er;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic rec_t dut_rec();
        rec_t r;
        r.iret  = out_iretired_o;
        r.exc   = out_exception_o;
        r.irq   = out_interrupt_o;
        r.pc    = out_pc_o;
        r.inst  = out_inst_o;
        r.comp  = out_compressed_o;
        r.cause = out_cause_o;
        r.tval  = out_tval_o;
        r.last  = out_last_o;
        return r;
    endfunction

    function automatic bun_t mk_bun(input logic [1:0] v, input logic [63:0] pc1, input logic [63:0] pc0,
                                    input logic [31:0] i1, input logic [31:0] i0, input logic [1:0] c,
                                    input logic e, input logic q, input logic [5:0] cause,
                                    input logic [63:0] tval, input logic [63:0] epc);
        bun_t b;
        b.valids = v;    b.pc = {pc1, pc0}; b.inst = {i1, i0}; b.comp = c;
        b.exc = e;       b.irq = q;         b.cause = cause;    b.tval = tval; b.epc = epc;
        return b;
    endfunction

    function automatic rec_t mk_irec(input logic [63:0] pc, input logic [31:0] inst,
                                     input logic comp, input logic last);
        rec_t r = '0;
        r.iret = 1'b1; r.pc = pc; r.inst = inst; r.comp = comp; r.last = last;
        return r;
    endfunction

    function automatic rec_t mk_trec(input logic e, input logic q, input logic [5:0] cause,
                                     input logic [63:0] tval, input logic [63:0] epc);
        rec_t r = '0;
        r.exc = e; r.irq = q; r.cause = cause; r.tval = tval; r.pc = epc; r.last = 1'b1;
        return r;
    endfunction

    task automatic drive(input bun_t b, input logic v);
        bundle_valid_i = v;
        valids_i       = b.valids;
        pc_i           = b.pc;
        inst_i         = b.inst;
        compressed_i   = b.comp;
        exception_i    = b.exc;
        interrupt_i    = b.irq;
        cause_i        = b.cause;
        tval_i         = b.tval;
        epc_i          = b.epc;
    endtask

    // Reference: a bundle expands into its set slots in order, then one trap record (interrupt wins).
    task automatic model_push(input bun_t b);
        rec_t rl [$];
        rec_t r;
        for (int k = 0; k < int'(NRET); k++) begin
            if (b.valids[k]) begin
                r = '0;
                r.iret = 1'b1;
                r.pc   = b.pc[k*XLEN +: XLEN];
                r.inst = b.inst[k*INST_LEN +: INST_LEN];
                r.comp = b.comp[k];
                rl.push_back(r);
            end
        end
        if (b.exc || b.irq) begin
            r = '0;
            r.irq = b.irq; r.exc = b.exc & ~b.irq;
            r.cause = b.cause; r.tval = b.tval; r.pc = b.epc;
            rl.push_back(r);
        end
        if (rl.size() > 0) begin
            rl[rl.size()-1].last = 1'b1;
            foreach (rl[i]) exp_q.push_back(rl[i]);
            bcnt_q.push_back(rl.size());
        end
    endtask

    function automatic bun_t rand_bun();
        bun_t b;
        int t;
        b.valids = NRET'($urandom_range(0, 3));
        b.pc     = {$urandom, $urandom, $urandom, $urandom};
        b.inst   = {$urandom, $urandom};
        b.comp   = NRET'($urandom_range(0, 3));
        t        = $urandom_range(0, 7);
        b.exc    = (t == 0) || (t == 2);
        b.irq    = (t == 1) || (t == 2);
        b.cause  = CAUSE_LEN'($urandom);
        b.tval   = {$urandom, $urandom};
        b.epc    = {$urandom, $urandom};
        return b;
    endfunction

    task automatic run_vec(input int vi, input vec_t v);
        @(negedge clk_i);
        drive(v.b, 1'b1);
        out_ready_i = 1'b1;
        chk($sformatf("v%0d_ready", vi), 256'(bundle_ready_o), 256'(1'b1));
        chk($sformatf("v%0d_pre_idle", vi), 256'(out_valid_o), 256'(1'b0));
        @(posedge clk_i);
        for (int j = 0; j < v.n; j++) begin
            @(negedge clk_i);
            bundle_valid_i = 1'b0;
            chk($sformatf("v%0d_valid%0d", vi, j), 256'(out_valid_o), 256'(1'b1));
            chk($sformatf("v%0d_rec%0d", vi, j), 256'(dut_rec()), 256'(v.exp[j]));
            @(posedge clk_i);
        end
        @(negedge clk_i);
        bundle_valid_i = 1'b0;
        chk($sformatf("v%0d_post_idle", vi), 256'(out_valid_o), 256'(1'b0));
    endtask

    initial begin
        rst_i = 1'b1;
        out_ready_i = 1'b0;
        drive('0, 1'b0);

        vecs[0].b = mk_bun(2'b11, 64'h1004, 64'h1000, 32'h0000_0093, 32'h0000_0013, 2'b00, 0, 0, 6'd0, 64'h0, 64'h0);
        vecs[0].n = 2;
        vecs[0].exp[0] = mk_irec(64'h1000, 32'h0000_0013, 1'b0, 1'b0);
        vecs[0].exp[1] = mk_irec(64'h1004, 32'h0000_0093, 1'b0, 1'b1);
        vecs[1].b = mk_bun(2'b10, 64'h2002, 64'h9999, 32'h0000_4501, 32'h1111_1111, 2'b10, 1, 0, 6'd2, 64'hDEAD, 64'h2004);
        vecs[1].n = 2;
        vecs[1].exp[0] = mk_irec(64'h2002, 32'h0000_4501, 1'b1, 1'b0);
        vecs[1].exp[1] = mk_trec(1'b1, 1'b0, 6'd2, 64'hDEAD, 64'h2004);
        vecs[2].b = mk_bun(2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 2'b00, 0, 1, 6'd7, 64'h0, 64'h3000);
        vecs[2].n = 1;
        vecs[2].exp[0] = mk_trec(1'b0, 1'b1, 6'd7, 64'h0, 64'h3000);
        vecs[3].b = mk_bun(2'b01, 64'h0, 64'h4000, 32'h0, 32'hABCD_0003, 2'b01, 1, 1, 6'd3, 64'h55, 64'h4002);
        vecs[3].n = 2;
        vecs[3].exp[0] = mk_irec(64'h4000, 32'hABCD_0003, 1'b1, 1'b0);
        vecs[3].exp[1] = mk_trec(1'b0, 1'b1, 6'd3, 64'h55, 64'h4002);
        vecs[4].b = mk_bun(2'b00, 64'h8888, 64'h7777, 32'h1, 32'h2, 2'b11, 0, 0, 6'd9, 64'h9, 64'h9);
        vecs[4].n = 0;
        vecs[5].b = mk_bun(2'b01, 64'hFFFF, 64'h4800, 32'h0, 32'h1234_5678, 2'b00, 0, 0, 6'd0, 64'h0, 64'h0);
        vecs[5].n = 1;
        vecs[5].exp[0] = mk_irec(64'h4800, 32'h1234_5678, 1'b0, 1'b1);

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_ready", 256'(bundle_ready_o), 256'(1'b1));
        chk("reset_valid", 256'(out_valid_o), 256'(1'b0));
        chk("reset_outs", 256'(dut_rec()), 256'(0));
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Backpressure: four bundles fill the FIFO, the fifth waits for the first pop.
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            drive(mk_bun(2'b11, 64'h5004 + 64'(i*256), 64'h5000 + 64'(i*256), 32'hA000_0001 + 32'(2*i),
                         32'hA000_0000 + 32'(2*i), 2'b00, 0, 0, 6'd0, 64'h0, 64'h0), 1'b1);
            chk($sformatf("bp_ready%0d", i), 256'(bundle_ready_o), 256'(1'b1));
            @(posedge clk_i);
        end
        @(negedge clk_i);
        drive(mk_bun(2'b11, 64'h5404, 64'h5400, 32'hA000_0009, 32'hA000_0008, 2'b00, 0, 0, 6'd0, 64'h0, 64'h0), 1'b1);
        chk("bp_full", 256'(bundle_ready_o), 256'(1'b0));
        chk("bp_hold", 256'(dut_rec()), 256'(mk_irec(64'h5000, 32'hA000_0000, 1'b0, 1'b0)));
        @(posedge clk_i);
        for (int r = 0; r < 10; r++) begin
            @(negedge clk_i);
            out_ready_i = 1'b1;
            if (r == 3) bundle_valid_i = 1'b0;
            chk($sformatf("bp_rec%0d", r), 256'(dut_rec()),
                256'(mk_irec(64'h5000 + 64'((r/2)*256 + (r%2)*4), 32'hA000_0000 + 32'(r), 1'b0, 1'(r%2))));
            if (r < 2)  chk($sformatf("bp_ready_lo%0d", r), 256'(bundle_ready_o), 256'(1'b0));
            if (r == 2) chk("bp_ready_after_pop", 256'(bundle_ready_o), 256'(1'b1));
            @(posedge clk_i);
        end
        @(negedge clk_i);
        chk("bp_idle", 256'(out_valid_o), 256'(1'b0));

        // Stall hold in the middle of a bundle that also carries a trap.
        drive(mk_bun(2'b11, 64'h7004, 64'h7000, 32'h0000_7001, 32'h0000_7000, 2'b10, 1, 0, 6'd5, 64'h77, 64'h7008), 1'b1);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bundle_valid_i = 1'b0;
        chk("st_rec0", 256'(dut_rec()), 256'(mk_irec(64'h7000, 32'h0000_7000, 1'b0, 1'b0)));
        @(posedge clk_i);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_i);
            out_ready_i = 1'b0;
            chk($sformatf("st_hold%0d", s), 256'(dut_rec()), 256'(mk_irec(64'h7004, 32'h0000_7001, 1'b1, 1'b0)));
            chk($sformatf("st_valid%0d", s), 256'(out_valid_o), 256'(1'b1));
            @(posedge clk_i);
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        chk("st_rec1", 256'(dut_rec()), 256'(mk_irec(64'h7004, 32'h0000_7001, 1'b1, 1'b0)));
        @(posedge clk_i);
        @(negedge clk_i);
        chk("st_trap", 256'(dut_rec()), 256'(mk_trec(1'b1, 1'b0, 6'd5, 64'h77, 64'h7008)));
        @(posedge clk_i);
        @(negedge clk_i);
        chk("st_idle", 256'(out_valid_o), 256'(1'b0));

        // Asynchronous reset between the two records of a bundle.
        drive(mk_bun(2'b11, 64'h6004, 64'h6000, 32'h6, 32'h5, 2'b00, 0, 0, 6'd0, 64'h0, 64'h0), 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        bundle_valid_i = 1'b0;
        chk("ar_rec0", 256'(dut_rec()), 256'(mk_irec(64'h6000, 32'h5, 1'b0, 1'b0)));
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("ar_valid", 256'(out_valid_o), 256'(1'b0));
        chk("ar_ready", 256'(bundle_ready_o), 256'(1'b1));
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk($sformatf("ar_quiet%0d", c), 256'(out_valid_o), 256'(1'b0));
        end

        // Random traffic against the queue model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk_i);
            rb  = rand_bun();
            rbv = ($urandom_range(0, 9) < 6);
            out_ready_i = ($urandom_range(0, 9) < 7);
            drive(rb, rbv);
            exp_rdy = (bcnt_q.size() < int'(DEPTH));
            chk("rnd_ready", 256'(bundle_ready_o), 256'(exp_rdy));
            chk("rnd_valid", 256'(out_valid_o), 256'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                er = exp_q[0];
                chk("rnd_rec", 256'(dut_rec()), 256'(er));
                if (out_ready_i) begin
                    void'(exp_q.pop_front());
                    bcnt_q[0]--;
                    if (bcnt_q[0] == 0) void'(bcnt_q.pop_front());
                end
            end
            if (rbv && exp_rdy) model_push(rb);
            @(posedge clk_i);
        end

        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            @(negedge clk_i);
            bundle_valid_i = 1'b0;
            out_ready_i = 1'b1;
            er = exp_q[0];
            chk("drain_rec", 256'(dut_rec()), 256'(er));
            void'(exp_q.pop_front());
            @(posedge clk_i);
        end
        @(negedge clk_i);
        chk("drain_empty", 256'(exp_q.size()), 256'(0));
        chk("drain_idle", 256'(out_valid_o), 256'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mure_retire_sequencer.md
Name: mure_retire_sequencer

Overview:
- Controller in front of the trace encoder's single-instruction input.
- Accepts one multi-retirement bundle per cycle from the CVA6 commit stage: up to NRET instructions plus one bundle-level trap.
- Buffers bundles in a DEPTH-entry FIFO and emits one record per cycle over a valid/ready handshake.
- Drains retired instructions in slot order, then emits a trap record if the bundle carried one.

Parameters:
- NRET, 2: commit slots per bundle (1..8).
- DEPTH, 4: bundle FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- bundle_valid_i  in  1  bundle offered.
- bundle_ready_o  out  1  bundle accepted this cycle if valid.
- valids_i  in  NRET  per-slot retired flag.
- pc_i  in  NRET*mure_pkg::XLEN  per-slot instruction address; slot k at bits [k*XLEN +: XLEN].
- inst_i  in  NRET*mure_pkg::INST_LEN  per-slot opcode.
- compressed_i  in  NRET  per-slot compressed flag.
- exception_i  in  1  bundle ends in an exception.
- interrupt_i  in  1  bundle ends in an interrupt.
- cause_i  in  mure_pkg::CAUSE_LEN  trap cause.
- tval_i  in  mure_pkg::XLEN  trap value.
- epc_i  in  mure_pkg::XLEN  trapping PC.
- out_valid_o  out  1  record available.
- out_ready_i  in  1  encoder consumes the record.
- out_iretired_o  out  1  record is a retired instruction.
- out_exception_o  out  1  record is an exception.
- out_interrupt_o  out  1  record is an interrupt.
- out_pc_o  out  mure_pkg::XLEN  instruction address, or epc for trap records.
- out_inst_o  out  mure_pkg::INST_LEN  opcode; 0 for trap records.
- out_compressed_o  out  1  compressed flag.
- out_cause_o  out  mure_pkg::CAUSE_LEN  cause; 0 unless trap record.
- out_tval_o  out  mure_pkg::XLEN  tval; 0 unless trap record.
- out_last_o  out  1  final record of the current bundle.

Behaviour:
- Reset:
  - FIFO empty, state IDLE.
  - bundle_ready_o=1; every other output is 0.
- Accept:
  - A bundle is accepted when bundle_valid_i & bundle_ready_o.
  - bundle_ready_o = !full. No same-cycle pop-to-push passthrough.
  - Bundles with valids_i==0 and no exception/interrupt are accepted and discarded; they are not written.
  - If exception_i & interrupt_i are both set, interrupt wins and is stored as a trap with interrupt=1, exception=0.
- Latency: a bundle accepted in cycle N is presented on out_* no earlier than cycle N+1.
- Head state: the head entry holds a remaining-slot mask, initialised to valids_i.
- FSM:
  - IDLE: FIFO empty; out_valid_o=0. Go to DRAIN when an entry exists.
  - DRAIN:
    - Present the lowest set bit k of the mask: iretired=1, pc/inst/compressed of slot k.
    - On handshake, clear bit k.
    - When the mask becomes 0: go to TRAP if the entry has a trap; otherwise pop and go to DRAIN or IDLE.
    - An entry with mask==0 and a trap enters TRAP directly.
  - TRAP:
    - Present the trap record: iretired=0, exception/interrupt, cause, tval, pc=epc.
    - On handshake, pop, then go to DRAIN or IDLE.
- out_last_o=1 on the final record of the entry: the trap record if present, else the last set slot.
- Outputs hold stable while out_valid_o & !out_ready_i (AXI-style). The mask is not modified during a stall.
- Simultaneous push and pop in the same cycle: legal. Count is unchanged and pointers both advance, wrapping modulo DEPTH.
- Full plus pop in the same cycle: bundle_ready_o stays 0 that cycle; the next cycle shows ready=1.
- Reset mid-operation: asynchronously empties the FIFO and aborts the current bundle; no partial record is emitted afterwards.

Optional Feature:
- Macro: MURE_SEQ_STATS_EN.
- When defined, adds three outputs: stat_bundles_o [31:0], stat_retired_o [31:0], stat_stall_o [31:0].
  - stat_bundles_o counts written bundles.
  - stat_retired_o counts handshaked iretired records.
  - stat_stall_o counts cycles with bundle_valid_i & !bundle_ready_o.
- Counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single bundle, out_ready_i=1:
  - Stimulus: NRET=2, valids=2'b11, pc={0x1004,0x1000}, no trap.
  - Response: records pc 0x1000 then 0x1004 in cycles N+1 and N+2; out_last_o only on 0x1004.
- Sparse plus trap:
  - Stimulus: valids=2'b10, pc1=0x2002, exception=1, cause=2, tval=0xDEAD, epc=0x2004.
  - Response: iretired record pc 0x2002 with last=0, then exception record cause 2, tval 0xDEAD, pc 0x2004, last=1.
- Trap only: valids=0, interrupt=1, cause=7 -> one record with interrupt=1, iretired=0, last=1.
- Backpressure:
  - Stimulus: push 5 full bundles back-to-back with out_ready_i=0.
  - Response: ready drops after 4 accepted. Release out_ready_i -> 8 records in order; the 5th bundle is accepted exactly one cycle after the first pop.
- Stall hold: deassert out_ready_i for 3 cycles mid-bundle -> out_* unchanged, no duplicated or skipped slot.
- Async reset: assert rst_i between records 1 and 2 of a bundle -> out_valid_o=0 immediately, bundle_ready_o=1; the remaining slot is never emitted.
